// File: rtl/irda_mir_oversample_decoder.sv
// irda_mir_oversample_decoder
// ---------------------------------------------------------------------------
// MIR bit-slot decoder with configurable oversampling. The receive sample is
// taken SAMPLES_PER_BIT times per slot and the high samples are counted. A
// slot whose count reaches THRESH carries an IR pulse and decodes to 0. A slot
// below THRESH decodes to 1. A late pulse leading edge closes the current slot
// early, so the slot phase follows the transmitter clock.
//
// Optional build macro: IRDA_MIR_RX_SYNC_EN
//   defined   - rx_i passes through a two-flop synchroniser before decoding.
//               This adds 2 clk of latency.
//   undefined - rx_i is used directly and must already be synchronous to clk.
// ---------------------------------------------------------------------------
module irda_mir_oversample_decoder #(
  parameter int SAMPLES_PER_BIT = 4,
  parameter int THRESH          = 1
) (
  input  logic clk,
  input  logic wb_rst_i,
  input  logic fast_enable,
  input  logic mir_mode,
  input  logic tx_select,
  input  logic rx_i,
  output logic mir_dec_o,
  output logic mir_dec_valid_o,
  output logic mir_resync_o
);

  // Slot counter and high-sample accumulator share one width. The
  // accumulator never exceeds SAMPLES_PER_BIT, so it needs no saturation.
  localparam int CW   = $clog2(SAMPLES_PER_BIT + 1);
  localparam int HALF = SAMPLES_PER_BIT / 2;

  localparam logic [CW-1:0] LAST_C   = CW'(SAMPLES_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_C   = CW'(HALF);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic          en;
  logic          rx_s;
  logic          rx_d;
  logic          rise;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] tot;
  logic          in_window;
  logic          do_resync;
  logic          do_slot_end;

  // The receiver runs only when MIR is selected, the fast path is enabled,
  // and this station is not transmitting.
  assign en = mir_mode & ~tx_select & fast_enable;

`ifdef IRDA_MIR_RX_SYNC_EN
  logic rx_meta;
  logic rx_sync;

  // Two-flop synchroniser for an asynchronous pin. It runs regardless of en,
  // so the pipe already holds current data when the receiver is enabled.
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
    end
  end

  assign rx_s = rx_sync;
`else
  assign rx_s = rx_i;
`endif

  // A leading edge of an IR pulse, seen as a low-to-high step between
  // consecutive enabled samples.
  assign rise = rx_s & ~rx_d;

  // Pulses must land near the start of a slot. An edge in the second half of
  // the slot, before the final sample, means this receiver is running ahead
  // of the transmitter. An edge on the final sample counts as in-phase. With
  // two samples per bit, this window contains no cnt values.
  assign in_window = (cnt >= HALF_C) && (cnt < LAST_C);

  // Slot-close decode: the resync branch has priority over the normal end.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    do_resync   = 1'b0;
    do_slot_end = 1'b0;
    tot         = hcnt + CW'(rx_s);
    if (rise && in_window) begin
      do_resync = 1'b1;
    end else if (cnt == LAST_C) begin
      do_slot_end = 1'b1;
    end
  end

  // Slot state machine: accumulate the samples, close the slot, and register
  // the decoded bit and the one-cycle strobes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
    if (wb_rst_i) begin
      cnt             <= '0;
      hcnt            <= '0;
      rx_d            <= 1'b0;
      mir_dec_o       <= 1'b0;
      mir_dec_valid_o <= 1'b0;
      mir_resync_o    <= 1'b0;
    end else if (!en) begin
      // Discard any partial slot. The decoded bit keeps its last value.
      cnt             <= '0;
      hcnt            <= '0;
      rx_d            <= 1'b0;
      mir_dec_valid_o <= 1'b0;
      mir_resync_o    <= 1'b0;
    end else begin
      rx_d <= rx_s;
      if (do_resync) begin
        // Close the slot early and decide on the samples already taken.
        // The edge sample is the first sample of the new slot.
        mir_dec_o       <= (hcnt >= THRESH_C) ? 1'b0 : 1'b1;
        mir_dec_valid_o <= 1'b1;
        mir_resync_o    <= 1'b1;
        cnt             <= ONE_C;
        hcnt            <= ONE_C;
      end else if (do_slot_end) begin
        mir_dec_o       <= (tot >= THRESH_C) ? 1'b0 : 1'b1;
        mir_dec_valid_o <= 1'b1;
        mir_resync_o    <= 1'b0;
        cnt             <= '0;
        hcnt            <= '0;
      end else begin
        mir_dec_valid_o <= 1'b0;
        mir_resync_o    <= 1'b0;
        cnt             <= cnt + ONE_C;
        hcnt            <= tot;
      end
    end
  end

endmodule

// File: tb/tb_irda_mir_oversample_decoder.sv
// tb_irda_mir_oversample_decoder
// Directed bench for the MIR oversampling decoder with SAMPLES_PER_BIT=4.
// u_dut uses THRESH=1 and u_dut_t2 uses THRESH=2. Both instances share the
// stimulus. Inputs change #1 after a rising edge, and outputs are read there.
module tb_irda_mir_oversample_decoder;

  logic clk;
  logic wb_rst_i;
  logic fast_enable;
  logic mir_mode;
  logic tx_select;
  logic rx_i;
  logic dec1, val1, rsy1;
  logic dec2, val2, rsy2;

  int n_checks = 0;
  int n_errors = 0;

  irda_mir_oversample_decoder #(.SAMPLES_PER_BIT(4), .THRESH(1)) u_dut (
    .clk             (clk),
    .wb_rst_i        (wb_rst_i),
    .fast_enable     (fast_enable),
    .mir_mode        (mir_mode),
    .tx_select       (tx_select),
    .rx_i            (rx_i),
    .mir_dec_o       (dec1),
    .mir_dec_valid_o (val1),
    .mir_resync_o    (rsy1)
  );

  irda_mir_oversample_decoder #(.SAMPLES_PER_BIT(4), .THRESH(2)) u_dut_t2 (
    .clk             (clk),
    .wb_rst_i        (wb_rst_i),
    .fast_enable     (fast_enable),
    .mir_mode        (mir_mode),
    .tx_select       (tx_select),
    .rx_i            (rx_i),
    .mir_dec_o       (dec2),
    .mir_dec_valid_o (val2),
    .mir_resync_o    (rsy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply one rx sample, then move to 1 time unit after the next rising edge.
  task automatic cyc(input logic r);
    rx_i = r;
    @(posedge clk);
    #1;
  endtask

  // Check all three outputs of the THRESH=1 instance.
  task automatic exp1(input string tag, input logic v, input logic rs, input logic d);
    check({tag, ".valid"}, val1, v);
    check({tag, ".resync"}, rsy1, rs);
    check({tag, ".dec"}, dec1, d);
  endtask

  initial begin
    wb_rst_i    = 1'b1;
    fast_enable = 1'b0;
    mir_mode    = 1'b0;
    tx_select   = 1'b0;
    rx_i        = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    exp1("reset", 1'b0, 1'b0, 1'b0);
    wb_rst_i    = 1'b0;
    fast_enable = 1'b1;
    mir_mode    = 1'b1;

`ifdef IRDA_MIR_RX_SYNC_EN
    // The decision appears 2 clk later. A pulse on rx_i at edge 3 is seen
    // at cnt=0 of slot 2, so it causes no resync.
    cyc(1'b0); cyc(1'b0); cyc(1'b1);
    check("sync.e3.valid", val1, 1'b0);
    cyc(1'b0);
    exp1("sync.e4", 1'b1, 1'b0, 1'b1);
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
    check("sync.e7.valid", val1, 1'b0);
    cyc(1'b0);
    exp1("sync.e8", 1'b1, 1'b0, 1'b0);
    check("sync.e8.t2dec", dec2, 1'b1);
`else
    // Test 1: 16 idle cycles produce a strobe every 4th cycle with decoded bit 1.
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0);
      check($sformatf("idle%0d.valid", k), val1, (k % 4) == 0);
      check($sformatf("idle%0d.resync", k), rsy1, 1'b0);
      if ((k % 4) == 0) check($sformatf("idle%0d.dec", k), dec1, 1'b1);
    end

    // Test 2/3a: one high sample at cnt=1 gives 0 for THRESH=1 and 1 for THRESH=2.
    cyc(1'b0); cyc(1'b1);
    check("t2.cnt1.valid", val1, 1'b0);
    check("t2.cnt1.resync", rsy1, 1'b0);
    cyc(1'b0); cyc(1'b0);
    exp1("t2.end", 1'b1, 1'b0, 1'b0);
    check("t3a.t2dec", dec2, 1'b1);
    check("t3a.t2valid", val2, 1'b1);
    cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b0);
    exp1("t2.zero", 1'b1, 1'b0, 1'b1);

    // Test 3b: two high samples at cnt=0 and cnt=1 give 0 for both thresholds.
    cyc(1'b1); cyc(1'b1); cyc(1'b0); cyc(1'b0);
    exp1("t3b", 1'b1, 1'b0, 1'b0);
    check("t3b.t2dec", dec2, 1'b0);

    // Test 4: a late rise at cnt=2 closes the slot early with decoded bit 1.
    // The next slot has 3 samples left and carries the pulse.
    cyc(1'b0); cyc(1'b0); cyc(1'b1);
    exp1("t4.resync", 1'b1, 1'b1, 1'b1);
    check("t4.t2resync", rsy2, 1'b1);
    cyc(1'b0);
    check("t4.n1.valid", val1, 1'b0);
    cyc(1'b0);
    check("t4.n2.valid", val1, 1'b0);
    cyc(1'b0);
    exp1("t4.after", 1'b1, 1'b0, 1'b0);
    check("t4.t2dec", dec2, 1'b1);

    // Test 5: tx_select is raised at cnt=2. Strobes stop, and the decoded
    // bit holds 0 even with rx high.
    cyc(1'b0); cyc(1'b0);
    tx_select = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1);
      exp1($sformatf("t5.tx%0d", k), 1'b0, 1'b0, 1'b0);
    end
    tx_select = 1'b0;
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
    check("t5.pre.valid", val1, 1'b0);
    cyc(1'b0);
    exp1("t5.first", 1'b1, 1'b0, 1'b1);

    // Test 6: reset at cnt=3 with rx high suppresses the strobe and clears
    // all outputs. The next slot then starts from cnt=0.
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
    wb_rst_i = 1'b1;
    cyc(1'b1);
    exp1("t6.rst", 1'b0, 1'b0, 1'b0);
    wb_rst_i = 1'b0;
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
    check("t6.pre.valid", val1, 1'b0);
    cyc(1'b0);
    exp1("t6.after", 1'b1, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
